// File: rtl/matriz_pkg.sv
// Shared definitions for the packed-matrix interface between the loader and
// the determinant/operation engines.
package matriz_pkg;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int TAM_MIN = 2;
  localparam int TAM_MAX = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } estado_t;

  // Bit offset of element (row,col) in the packed bus; the stride stays at
  // MAX_DIM regardless of N so that consumers can index it statically.
  function automatic logic [7:0] slot_offset(input logic [2:0] row, input logic [2:0] col);
    logic [7:0] idx;
    idx = 8'd5 * {5'd0, row} + {5'd0, col};
    return idx << 3;
  endfunction

endpackage

// File: rtl/matriz_carregador.sv
// Byte-serial loader: assembles N x N signed elements into the packed matrix
// bus and holds it until the consumer acknowledges.
module matriz_carregador #(
  parameter int MAX_DIM = 5,
  parameter int ELEM_W  = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                cfg_valid,
  input  logic [7:0]                          cfg_tamanho,
  output logic                                cfg_ready,
  input  logic                                elem_valid,
  input  logic [ELEM_W-1:0]                   elem_data,
  output logic                                elem_ready,
  input  logic                                cancel,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matriz,
  output logic [7:0]                          tamanho,
  output logic                                matriz_valid,
  input  logic                                matriz_ack,
  output logic                                erro
);
  import matriz_pkg::*;

  estado_t    estado, estado_nx;
  logic [7:0] n_reg;
  logic [2:0] row, col;
  logic [2:0] n_ult;
  logic       tam_ok;
  logic       xfer;
  logic       fim;

  // Full 8-bit compare so no upper-bit aliasing can sneak a size through.
  assign tam_ok = (cfg_tamanho >= 8'(TAM_MIN)) && (cfg_tamanho <= 8'(TAM_MAX));
  assign n_ult  = n_reg[2:0] - 3'd1;
  assign xfer   = (estado == LOAD) && elem_valid && !cancel;
  assign fim    = (row == n_ult) && (col == n_ult);

  assign cfg_ready    = (estado == IDLE);
  assign elem_ready   = (estado == LOAD);
  assign matriz_valid = (estado == HOLD);
  assign tamanho      = (estado == HOLD) ? n_reg : 8'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_nx;
  end

  always_comb begin
    estado_nx = estado;
    case (estado)
      IDLE: if (cfg_valid && tam_ok) estado_nx = LOAD;
      LOAD: begin
        if (cancel)                 estado_nx = IDLE;
        else if (elem_valid && fim) estado_nx = HOLD;
      end
      HOLD: if (matriz_ack) estado_nx = IDLE;
      default: estado_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_reg  <= 8'd0;
      row    <= 3'd0;
      col    <= 3'd0;
      matriz <= '0;
      erro   <= 1'b0;
    end else begin
      erro <= (estado == IDLE) && cfg_valid && !tam_ok;
      if ((estado == IDLE) && cfg_valid && tam_ok) begin
        n_reg  <= cfg_tamanho;
        row    <= 3'd0;
        col    <= 3'd0;
        matriz <= '0;
      end
      if (xfer) begin
        matriz[slot_offset(row, col) +: ELEM_W] <= elem_data;
        if (col == n_ult) begin
          col <= 3'd0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matriz_carregador.sv
// Scoreboard bench for matriz_carregador: expected matrices are queued as
// elements are driven and compared when matriz_valid rises.
module tb_matriz_carregador;

  logic         clock = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic [7:0]   cfg_tamanho;
  logic         cfg_ready;
  logic         elem_valid;
  logic [7:0]   elem_data;
  logic         elem_ready;
  logic         cancel;
  logic [199:0] matriz;
  logic [7:0]   tamanho;
  logic         matriz_valid;
  logic         matriz_ack;
  logic         erro;

  matriz_carregador dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_tamanho  (cfg_tamanho),
    .cfg_ready    (cfg_ready),
    .elem_valid   (elem_valid),
    .elem_data    (elem_data),
    .elem_ready   (elem_ready),
    .cancel       (cancel),
    .matriz       (matriz),
    .tamanho      (tamanho),
    .matriz_valid (matriz_valid),
    .matriz_ack   (matriz_ack),
    .erro         (erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [199:0] m;
    logic [7:0]   t;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [199:0] model_m;
  int           cur_r, cur_c, cur_n;
  logic         mv_prev = 1'b0;
  logic [199:0] snap;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: pop the expected matrix on each rising edge of matriz_valid.
  always @(negedge clock) begin
    if (matriz_valid === 1'b1 && mv_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", {199'd0, matriz_valid}, 200'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_matriz", matriz, e.m);
        check("sb_tamanho", {192'd0, tamanho}, {192'd0, e.t});
      end
    end
    mv_prev = matriz_valid;
  end

  task automatic do_cfg(input logic [7:0] n);
    @(negedge clock);
    cfg_valid   = 1'b1;
    cfg_tamanho = n;
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
    if (n >= 8'd2 && n <= 8'd5) begin
      model_m = '0;
      cur_r   = 0;
      cur_c   = 0;
      cur_n   = int'(n);
    end
  endtask

  // Drives one element for one cycle; transfer occurs at the following edge.
  task automatic push_elem(input logic [7:0] d);
    @(negedge clock);
    elem_valid = 1'b1;
    elem_data  = d;
    model_m[(cur_r * 5 + cur_c) * 8 +: 8] = d;
    if (cur_r == cur_n - 1 && cur_c == cur_n - 1) begin
      exp_t e;
      e.m = model_m;
      e.t = 8'(cur_n);
      sb_q.push_back(e);
    end
    if (cur_c == cur_n - 1) begin
      cur_c = 0;
      cur_r++;
    end else begin
      cur_c++;
    end
  endtask

  task automatic gap_cycle();
    @(negedge clock);
    elem_valid = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clock);
    matriz_ack = 1'b1;
    @(posedge clock);
    #1;
    matriz_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_tamanho = 8'd0; elem_valid = 1'b0;
    elem_data = 8'd0; cancel = 1'b0; matriz_ack = 1'b0;
    cur_r = 0; cur_c = 0; cur_n = 2; model_m = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_matriz", matriz, 200'd0);
    check("rst_tamanho", {192'd0, tamanho}, 200'd0);
    check("rst_valid", {199'd0, matriz_valid}, 200'd0);
    check("rst_elem_ready", {199'd0, elem_ready}, 200'd0);
    check("rst_erro", {199'd0, erro}, 200'd0);
    check("rst_cfg_ready", {199'd0, cfg_ready}, 200'd1);
    @(negedge clock);
    reset = 1'b0;

    // N=5, elements 1..25 back to back
    do_cfg(8'd5);
    check("n5_elem_ready", {199'd0, elem_ready}, 200'd1);
    check("n5_cfg_ready", {199'd0, cfg_ready}, 200'd0);
    for (int i = 1; i <= 25; i++) begin
      push_elem(8'(i));
      check("n5_ready_during", {199'd0, elem_ready}, 200'd1);
      if (i == 25) check("n5_valid_early", {199'd0, matriz_valid}, 200'd0);
    end
    @(posedge clock);
    #1;
    elem_valid = 1'b0;
    check("n5_valid_rise", {199'd0, matriz_valid}, 200'd1);
    check("n5_byte0", {192'd0, matriz[7:0]}, 200'd1);
    check("n5_byte24", {192'd0, matriz[199:192]}, 200'd25);
    check("n5_tamanho", {192'd0, tamanho}, 200'd5);
    do_ack();
    check("n5_ack_cfg_ready", {199'd0, cfg_ready}, 200'd1);
    check("n5_ack_tamanho", {192'd0, tamanho}, 200'd0);
    check("n5_ack_valid", {199'd0, matriz_valid}, 200'd0);

    // N=3, elements -1..-9 with elem_valid toggling
    do_cfg(8'd3);
    for (int i = 1; i <= 9; i++) begin
      push_elem(8'(-i));
      if (i < 9) gap_cycle();
    end
    @(posedge clock);
    #1;
    elem_valid = 1'b0;
    check("n3_valid_rise", {199'd0, matriz_valid}, 200'd1);
    check("n3_row0", {176'd0, matriz[23:0]}, {176'd0, 24'hFDFEFF});
    check("n3_row1", {176'd0, matriz[63:40]}, {176'd0, 24'hFAFBFC});
    check("n3_row2", {176'd0, matriz[103:80]}, {176'd0, 24'hF7F8F9});
    check("n3_b3_4", {184'd0, matriz[39:24]}, 200'd0);
    check("n3_b8_9", {184'd0, matriz[79:64]}, 200'd0);
    check("n3_b13_24", {104'd0, matriz[199:104]}, 200'd0);
    do_ack();

    // Illegal sizes
    snap = matriz;
    foreach (sb_q[i]) ;
    begin
      logic [7:0] bad [3];
      bad[0] = 8'd1; bad[1] = 8'd6; bad[2] = 8'd13;
      for (int k = 0; k < 3; k++) begin
        do_cfg(bad[k]);
        check("ill_erro_pulse", {199'd0, erro}, 200'd1);
        check("ill_cfg_ready", {199'd0, cfg_ready}, 200'd1);
        check("ill_elem_ready", {199'd0, elem_ready}, 200'd0);
        @(posedge clock);
        #1;
        check("ill_erro_low", {199'd0, erro}, 200'd0);
        check("ill_matriz", matriz, snap);
      end
    end

    // N=4, 7 elements then cancel with a simultaneous element
    do_cfg(8'd4);
    for (int i = 1; i <= 7; i++) push_elem(8'(8'h40 + i));
    @(negedge clock);
    elem_valid = 1'b1;
    elem_data  = 8'h77;
    cancel     = 1'b1;
    @(posedge clock);
    #1;
    cancel     = 1'b0;
    elem_valid = 1'b0;
    check("can_cfg_ready", {199'd0, cfg_ready}, 200'd1);
    check("can_elem_ready", {199'd0, elem_ready}, 200'd0);
    check("can_matriz", matriz, model_m);
    check("can_byte8", {192'd0, matriz[71:64]}, 200'd0);
    repeat (3) begin
      @(posedge clock);
      #1;
      check("can_no_valid", {199'd0, matriz_valid}, 200'd0);
    end

    // N=2, then tamper with inputs during HOLD
    do_cfg(8'd2);
    for (int i = 0; i < 4; i++) push_elem(8'($urandom_range(0, 255)));
    @(posedge clock);
    #1;
    elem_valid = 1'b0;
    check("hold_valid", {199'd0, matriz_valid}, 200'd1);
    snap = matriz;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      cfg_valid   = 1'b1;
      cfg_tamanho = 8'd3;
      elem_valid  = 1'b1;
      elem_data   = 8'($urandom_range(0, 255));
      @(posedge clock);
      #1;
      check("hold_matriz", matriz, snap);
      check("hold_tamanho", {192'd0, tamanho}, 200'd2);
      check("hold_elem_ready", {199'd0, elem_ready}, 200'd0);
    end
    @(negedge clock);
    cfg_valid  = 1'b0;
    elem_valid = 1'b0;

    // Asynchronous reset mid-HOLD
    check("prerst_valid", {199'd0, matriz_valid}, 200'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_matriz", matriz, 200'd0);
    check("arst_valid", {199'd0, matriz_valid}, 200'd0);
    check("arst_tamanho", {192'd0, tamanho}, 200'd0);
    check("arst_cfg_ready", {199'd0, cfg_ready}, 200'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("sb_drain", 200'(sb_q.size()), 200'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
